gate_activation_collector: RTL



---
 rtl/gate_activation_collector_pkg.sv | 35 +++
 rtl/gate_activation_collector_if.sv | 24 ++
 rtl/gate_activation_collector_pwl.sv | 33 +++
 rtl/gate_activation_collector.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/gate_activation_collector_pkg.sv
// Shared types, Q4.12 constants and saturation helper for the gate activation collector.
// Imported by the activation sub-module and the top.
package gate_act_pkg;

  localparam int DEF_MAX_ROWS   = 64;
  localparam int DEF_BANDWIDTH  = 16;
  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ACT_IDENTITY = 2'd0,
    ACT_HSIGMOID = 2'd1,
    ACT_HTANH    = 2'd2,
    ACT_RSVD     = 2'd3
  } act_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic signed [15:0] Q_ONE  = 16'sd4096;
  localparam logic signed [15:0] Q_HALF = 16'sd2048;
  localparam logic signed [15:0] Q_MAX  = 16'sh7FFF;
  localparam logic signed [15:0] Q_MIN  = 16'sh8000;

  // Clamp a 17-bit intermediate sum back into the signed 16-bit Q4.12 range.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v > 17'sd32767)       return Q_MAX;
    else if (v < -17'sd32768) return Q_MIN;
    else                      return v[15:0];
  endfunction

endpackage

// File: rtl/gate_activation_collector_if.sv
// Chunked vector output bus; same chunk shape as the multiplier's vector-load port.
interface gate_activation_collector_if #(
  parameter int AW         = 6,
  parameter int BANDWIDTH  = 16,
  parameter int DATA_WIDTH = 16
) ();

  logic                         out_valid;
  logic                         out_ready;
  logic [AW-1:0]                out_base_addr;
  logic signed [DATA_WIDTH-1:0] out_data [0:BANDWIDTH-1];
  logic                         out_last;

  modport master (
    output out_valid, out_base_addr, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_base_addr, out_data, out_last,
    output out_ready
  );

endinterface

// File: rtl/gate_activation_collector_pwl.sv
// Combinational piecewise-linear activation on a saturated Q4.12 sum.
module pwl_activation
  import gate_act_pkg::*;
(
  input  logic signed [15:0] sum,
  input  act_mode_t          mode,
  output logic signed [15:0] y
);

  logic signed [16:0] sum_ext;
  logic signed [16:0] sig_pre;

  // Hard sigmoid is sum/4 + 0.5, evaluated at 17 bits so the offset cannot wrap.
  always_comb begin
    sum_ext = 17'(sum);
    sig_pre = (sum_ext >>> 2) + 17'sd2048;
    y       = sum;
    case (mode)
      ACT_HSIGMOID: begin
        if (sig_pre < 17'sd0)         y = 16'sd0;
        else if (sig_pre > 17'sd4096) y = Q_ONE;
        else                          y = sig_pre[15:0];
      end
      ACT_HTANH: begin
        if (sum > Q_ONE)       y = Q_ONE;
        else if (sum < -Q_ONE) y = -Q_ONE;
        else                   y = sum;
      end
      default: y = sum;
    endcase
  end

endmodule

// File: rtl/gate_activation_collector.sv
// Bias-add, activation and vector buffering for matvec row results; drains the
// finished vector as fixed-width chunks over a valid/ready bus.
module gate_activation_collector
  import gate_act_pkg::*;
#(
  parameter int MAX_ROWS   = DEF_MAX_ROWS,
  parameter int BANDWIDTH  = DEF_BANDWIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [$clog2(MAX_ROWS)-1:0]   num_rows,
  input  logic [1:0]                    act_mode,
  input  logic                          bias_we,
  input  logic [$clog2(MAX_ROWS)-1:0]   bias_addr,
  input  logic signed [DATA_WIDTH-1:0]  bias_in,
  input  logic signed [DATA_WIDTH-1:0]  result_in,
  input  logic                          result_valid_in,
  gate_activation_collector_if.master   out_if,
  output logic                          busy,
  output logic                          done
);

  localparam int AW = $clog2(MAX_ROWS);

  state_t          state_q, state_d;
  logic [AW-1:0]   row_cnt_q, row_cnt_d;
  logic [AW-1:0]   num_rows_q, num_rows_d;
  act_mode_t       act_mode_q, act_mode_d;
  logic [AW-1:0]   base_q, base_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic signed [DATA_WIDTH-1:0] bias_mem_q [0:MAX_ROWS-1];
  logic signed [DATA_WIDTH-1:0] vec_buf_q  [0:MAX_ROWS-1];

  logic signed [DATA_WIDTH-1:0] bias_rd;
  logic signed [16:0]           sum_raw;
  logic signed [15:0]           sum_sat;
  logic signed [15:0]           act_y;
  logic                         row_fire;
  logic                         last_row;
  logic [AW+1:0]                reach;

  assign row_fire = (state_q == ST_COLLECT) && result_valid_in;
  assign last_row = ((AW+1)'(row_cnt_q) + (AW+1)'(1)) == (AW+1)'(num_rows_q);
  assign bias_rd  = bias_mem_q[row_cnt_q];
  assign sum_raw  = 17'(result_in) + 17'(bias_rd);
  assign sum_sat  = sat16(sum_raw);

  pwl_activation u_pwl (
    .sum  (sum_sat),
    .mode (act_mode_q),
    .y    (act_y)
  );

  // Read-before-write: a bias write landing on the row being processed is seen next time.
  always_ff @(posedge clk) begin
    if (bias_we) bias_mem_q[bias_addr] <= bias_in;
  end

  always_ff @(posedge clk) begin
    if (row_fire) vec_buf_q[row_cnt_q] <= act_y;
  end

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    num_rows_d = num_rows_q;
    act_mode_d = act_mode_q;
    base_d     = base_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_rows_d = num_rows;
          act_mode_d = act_mode_t'(act_mode);
          row_cnt_d  = '0;
          base_d     = '0;
          state_d    = (num_rows == '0) ? ST_DONE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (result_valid_in) begin
          row_cnt_d = row_cnt_q + AW'(1);
          if (last_row) begin
            state_d = ST_DRAIN;
            base_d  = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (out_if.out_ready) begin
          if (out_last_q) state_d = ST_DONE;
          else            base_d  = base_q + AW'(BANDWIDTH);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered from the next-state view so they line up with the state.
    reach       = (AW+2)'(base_d) + (AW+2)'(BANDWIDTH);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    out_valid_d = (state_d == ST_DRAIN);
    out_last_d  = out_valid_d && (reach >= (AW+2)'(num_rows_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      row_cnt_q   <= '0;
      num_rows_q  <= '0;
      act_mode_q  <= ACT_IDENTITY;
      base_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      num_rows_q  <= num_rows_d;
      act_mode_q  <= act_mode_d;
      base_q      <= base_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  for (genvar g = 0; g < BANDWIDTH; g++) begin : g_out
    logic [AW+1:0] idx;
    assign idx = (AW+2)'(base_q) + (AW+2)'(g);
    assign out_if.out_data[g] = (out_valid_q && (idx < (AW+2)'(num_rows_q)))
                                ? vec_buf_q[idx[AW-1:0]] : '0;
  end

  assign out_if.out_valid     = out_valid_q;
  assign out_if.out_base_addr = base_q;
  assign out_if.out_last      = out_last_q;
  assign busy                 = busy_q;
  assign done                 = done_q;

endmodule
